serial_add_sub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor; generalises the 1-bit half/full adder/subtractor cells to WIDTH bits.

---
 rtl/serial_add_sub_if.sv | 26 ++
 rtl/serial_add_sub.sv | 117 +++++++++++
 tb/tb_serial_add_sub.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub.
// The master drives operands and consumes results; the slave is the arithmetic unit.
interface serial_add_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, carry/borrow
// kept in a register between steps. Valid/ready handshake on both sides.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input logic              clk,
    input logic              rst,
    serial_add_sub_if.slave  bus
);
    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
        $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             mode_r;
    logic             cy;
    logic             cout_r;
    logic             ovf_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             c_out;
    logic             c_msb_in;
    logic             last;

    assign last = (cnt == CW'(STEPS - 1));

    // Inverting a turns the full-adder carry equation into the borrow equation.
    always_comb begin
        dsum     = '0;
        c_msb_in = 1'b0;
        c_out    = cy;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            c_msb_in = c_out;
            dsum[i]  = a_sh[i] ^ b_sh[i] ^ c_out;
            c_out    = ((a_sh[i] ^ mode_r) & b_sh[i]) | (b_sh[i] & c_out)
                     | (c_out & (a_sh[i] ^ mode_r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Result digits enter at the top and shift down, so after STEPS steps
    // digit k sits at bits [k*DIGIT +: DIGIT].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            mode_r <= 1'b0;
            cy     <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        mode_r <= bus.mode;
                        cy     <= 1'b0;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= (res_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                    cy     <= c_out;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        cout_r <= c_out;
                        ovf_r  <= c_msb_in ^ c_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_sh;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench: directed vectors on an 8-bit/1-digit unit, model-checked
// random operations on a 16-bit/4-digit unit.
module tb_serial_add_sub;
    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb8[$];
    exp_t sb16[$];

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8))  if8 ();
    serial_add_sub_if #(.WIDTH(16)) if16 ();

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int unsigned w, input logic [15:0] a,
                                   input logic [15:0] b, input logic m);
        exp_t        e;
        int unsigned mask;
        int unsigned ua;
        int unsigned ub;
        int unsigned r;
        int unsigned sa;
        int unsigned sb;
        int unsigned sr;
        mask = (1 << w) - 1;
        ua   = 32'(a) & mask;
        ub   = 32'(b) & mask;
        if (!m) begin
            r      = ua + ub;
            e.cout = (r > mask);
        end else begin
            r      = ua - ub;
            e.cout = (ua < ub);
        end
        r  = r & mask;
        sa = (ua >> (w - 1)) & 1;
        sb = (ub >> (w - 1)) & 1;
        sr = (r  >> (w - 1)) & 1;
        e.ovf = m ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        e.res = 16'(r);
        return e;
    endfunction

    // Monitors: a result is consumed on every out_valid & out_ready edge.
    always @(negedge clk) begin
        if (!rst && if8.out_valid && if8.out_ready) begin
            if (sb8.size() == 0) begin
                check("unexpected_out8", 32'(if8.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                check("result8", 32'(if8.result), 32'(e.res[7:0]));
                check("cout8",   32'(if8.cout),   32'(e.cout));
                check("ovf8",    32'(if8.ovf),    32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if16.out_valid && if16.out_ready) begin
            if (sb16.size() == 0) begin
                check("unexpected_out16", 32'(if16.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb16.pop_front();
                check("result16", 32'(if16.result), 32'(e.res));
                check("cout16",   32'(if16.cout),   32'(e.cout));
                check("ovf16",    32'(if16.ovf),    32'(e.ovf));
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic m);
        int lat;
        lat = -1;
        check("in_ready8_before", 32'(if8.in_ready), 32'd1);
        if8.a = a;
        if8.b = b;
        if8.mode = m;
        if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (if8.out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency8", 32'(lat), 32'd8);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic m);
        int lat;
        lat = -1;
        for (int n = 0; n < 40 && !if16.in_ready; n++) begin
            @(posedge clk); #1;
        end
        if16.a = a;
        if16.b = b;
        if16.mode = m;
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (if16.out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency16", 32'(lat), 32'd4);
        for (int n = 0; n < 200 && if16.out_valid; n++) begin
            if16.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        if16.out_ready = 1'b1;
    endtask

    vec_t vecs[8] = '{
        '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
        '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0},
        '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1},
        '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0},
        '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1}
    };

    initial begin
        if8.in_valid  = 1'b0;
        if8.a         = '0;
        if8.b         = '0;
        if8.mode      = 1'b0;
        if8.out_ready = 1'b1;
        if16.in_valid  = 1'b0;
        if16.a         = '0;
        if16.b         = '0;
        if16.mode      = 1'b0;
        if16.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",  32'(if8.in_ready),  32'd1);
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_result",    32'(if8.result),    32'd0);
        check("rst_cout",      32'(if8.cout),      32'd0);
        check("rst_ovf",       32'(if8.ovf),       32'd0);
        check("rst_out_valid16", 32'(if16.out_valid), 32'd0);

        foreach (vecs[i]) begin
            sb8.push_back('{res: 16'(vecs[i].res), cout: vecs[i].cout, ovf: vecs[i].ovf});
            issue8(vecs[i].a, vecs[i].b, vecs[i].m);
            @(posedge clk); #1;
        end

        // Backpressure: result frozen, new operands ignored while in DONE.
        if8.out_ready = 1'b0;
        sb8.push_back('{res: 16'h0046, cout: 1'b0, ovf: 1'b0});
        issue8(8'h12, 8'h34, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_result",    32'(if8.result),    32'h46);
            check("bp_out_valid", 32'(if8.out_valid), 32'd1);
            check("bp_in_ready",  32'(if8.in_ready),  32'd0);
            if (k == 1) begin
                if8.a = 8'hAA;
                if8.b = 8'h55;
                if8.mode = 1'b1;
                if8.in_valid = 1'b1;
            end else begin
                if8.in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  32'(if8.in_ready),  32'd1);
        check("bp_release_out_valid", 32'(if8.out_valid), 32'd0);
        check("bp_release_hold",      32'(if8.result),    32'h46);
        sb8.push_back('{res: 16'h008F, cout: 1'b0, ovf: 1'b0});
        issue8(8'h9A, 8'h0B, 1'b1);
        @(posedge clk); #1;

        // Reset while the step counter is at 3.
        if8.a = 8'h11;
        if8.b = 8'h22;
        if8.mode = 1'b0;
        if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready",  32'(if8.in_ready),  32'd1);
        check("midrst_out_valid", 32'(if8.out_valid), 32'd0);
        check("midrst_result",    32'(if8.result),    32'd0);
        check("midrst_cout",      32'(if8.cout),      32'd0);
        check("midrst_ovf",       32'(if8.ovf),       32'd0);
        sb8.push_back('{res: 16'h0002, cout: 1'b0, ovf: 1'b0});
        issue8(8'h01, 8'h01, 1'b0);
        @(posedge clk); #1;

        // Reset and in_valid on the same edge: operands must not be captured.
        if8.a = 8'h44;
        if8.b = 8'h44;
        if8.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if8.in_valid = 1'b0;
        check("rst_vs_valid_in_ready", 32'(if8.in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1 check("rst_vs_valid_no_out", 32'(if8.out_valid), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rm;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            sb16.push_back(model(16, ra, rb, rm));
            issue16(ra, rb, rm);
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb8_drained",  32'(sb8.size()),  32'd0);
        check("sb16_drained", 32'(sb16.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
